stack_rr_arbiter: RTL and testbench
===================================

// Module: stack_rr_arbiter
// PURPOSE
//  Shares one LIFO stack between two requesters (client 0, client 1) with round-robin arbitration.
//  Each client issues push/pop/peek transactions over a req/ack handshake and gets pop data plus an error flag back.
//  Sits between the stack storage and the two producer/consumer engines, and owns all push/pop sequencing.
// PARAMETERS
//  DATA_W   8    stack word width
//  DEPTH    16   stack entries (power of two)
//  LVL_W    $clog2(DEPTH)+1   width of the level output (derived localparam)
// PORTS
//  clk         in   1        single clock, rising edge
//  rst         in   1        synchronous, active-high reset
//  c0_req      in   1        client 0 request; held high with c0_op/c0_wdata stable until c0_ack
//  c0_op       in   2        00 push, 01 pop, 10 peek, 11 reserved
//  c0_wdata    in   DATA_W   push data
//  c0_ack      out  1        one-cycle completion pulse
//  c0_rdata    out  DATA_W   pop/peek result, valid with c0_ack and held until the next ack to client 0
//  c0_err      out  1        valid with c0_ack: op rejected
//  c1_*        (same set as c0_*, for client 1)
//  level       out  LVL_W    current number of stored entries
//  full, empty out  1        level==DEPTH / level==0
//  busy        out  1        FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE; stack emptied (level=0, empty=1, full=0); all ack/err=0; rdata=0; busy=0; rr_last=1 (client 0 wins first tie).
//  FSM: IDLE -> GRANT -> ACK -> IDLE. Exactly one transaction is in flight.
//   IDLE: if any req is high, choose the winner, latch its id/op/wdata, and go to GRANT.
//         Single requester wins. Both requesting: client != rr_last wins.
//   GRANT: check legality. push needs !full; pop and peek need !empty.
//          Legal push: drive one push (wr_data=wdata). Legal pop: capture top into rdata, then drive one pop.
//          Peek: capture top only. Illegal op: no stack op, err_pending=1. Go to ACK.
//   ACK: pulse ack of the winner for one cycle, with err; update rr_last=winner; go to IDLE.
//  Latency: req seen in IDLE -> ack 2 cycles later; 3 cycles per transaction.
//   A client that keeps req high after ack starts a new transaction (back-to-back allowed, subject to round-robin).
//  rdata is unchanged on push and on error. Requests from the loser wait; a request is never dropped.
//  Requester must not drop req before ack. If it does, behaviour is undefined.
//  Stack ops never occur outside GRANT, and push and pop are never asserted together.
//  level/full/empty update the cycle after GRANT.
//  Boundaries:
//   - push at level==DEPTH: err=1, contents unchanged.
//   - pop/peek at level==0: err=1, rdata unchanged.
//   - op 11: err=1.
//   - rst asserted mid-transaction: abort with no ack; stack emptied.
// CONFIGURATION
//  STACK_ARB_PEEK_EN defined: op 10 returns the top entry without popping (err if empty).
//  STACK_ARB_PEEK_EN undefined: op 10 is treated as reserved (err=1, no stack op). Peek capture logic is not built.
// STRUCTURE
//  Package stack_arb_pkg: op_e enum (OP_PUSH, OP_POP, OP_PEEK, OP_RSVD), state_e (S_IDLE, S_GRANT, S_ACK).
//  Sub-module lifo_core #(DATA_W, DEPTH):
//   - ports: clk, rst, push, pop, wr_data, rd_data (top entry, combinational), level, full, empty
//   - storage is an array indexed by a pointer
//  This top holds the FSM, round-robin logic, latches and per-client outputs.
// TESTING
//  1. Reset, then c0 pushes 0xA5 -> c0_ack 2 cycles after req, err=0, level=1.
//     Then c1 pops -> c1_rdata=0xA5, err=0, level=0, empty=1.
//  2. Both clients hold req with pushes of 0x01 (c0) and 0x02 (c1) at the same time -> grant order c0, c1, c0, c1.
//     The acks alternate and never overlap.
//  3. Push 16 values 0xF0..0xFF -> full=1. A 17th push gets err=1 and level stays 16.
//     16 pops then return 0xFF down to 0xF0.
//  4. Pop when empty -> err=1, rdata keeps its previous value.
//     Op 11 -> err=1 and no level change.
//  5. Assert rst in the GRANT cycle of a push at level=5 -> no ack; next cycle level=0, empty=1, busy=0.
//  6. Peek at level=3 with top 0x33:
//     - STACK_ARB_PEEK_EN defined -> rdata=0x33, err=0, level=3.
//     - STACK_ARB_PEEK_EN undefined -> err=1.

Source files
------------

// File: rtl/stack_arb_pkg.sv
// Shared types and the round-robin pick helper for stack_rr_arbiter.
// Peek support is selected by the STACK_ARB_PEEK_EN macro in the top.
package stack_arb_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_PEEK = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01,
    S_ACK   = 2'b10
  } state_e;

  // Returns the winning client id; on a tie the client that did not win last goes first.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic rr_last);
    logic win;
    if (req0 && req1) begin
      win = ~rr_last;
    end else if (req1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

endpackage

// File: rtl/lifo_core.sv
// Pointer-indexed LIFO storage; the level register doubles as the write pointer.
module lifo_core #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int LVL_W  = $clog2(DEPTH) + 1,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [LVL_W-1:0]  level_r;
  logic [LVL_W-1:0]  level_nxt_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [IDX_W-1:0]  top_idx_s;
  logic              full_r;
  logic              empty_r;

  // Next level and pointer decode; at level==DEPTH the index wraps so the top is still DEPTH-1.
  always_comb begin
    wr_idx_s    = level_r[IDX_W-1:0];
    top_idx_s   = wr_idx_s - {{(IDX_W-1){1'b0}}, 1'b1};
    level_nxt_s = level_r;
    if (push && !full_r) begin
      level_nxt_s = level_r + {{(LVL_W-1){1'b0}}, 1'b1};
    end else if (pop && !empty_r) begin
      level_nxt_s = level_r - {{(LVL_W-1){1'b0}}, 1'b1};
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Level and registered full/empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r <= {LVL_W{1'b0}};
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == LVL_W'(DEPTH));
      empty_r <= (level_nxt_s == {LVL_W{1'b0}});
    end
  end

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push && !full_r) begin
      mem_r[wr_idx_s] <= wr_data;
    end
  end

  assign rd_data = mem_r[top_idx_s];
  assign level   = level_r;
  assign full    = full_r;
  assign empty   = empty_r;

endmodule

// File: rtl/stack_rr_arbiter.sv
// Two-client round-robin front end for a shared LIFO (IDLE -> GRANT -> ACK).
// Define STACK_ARB_PEEK_EN to enable op 10 (peek); otherwise it is rejected as reserved.
module stack_rr_arbiter
  import stack_arb_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_req,
  input  logic [1:0]        c0_op,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_ack,
  output logic [DATA_W-1:0] c0_rdata,
  output logic              c0_err,
  input  logic              c1_req,
  input  logic [1:0]        c1_op,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_ack,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              c1_err,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty,
  output logic              busy
);

  state_e            state_r;
  logic              win_r;
  logic              rr_last_r;
  op_e               op_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] top_s;
  logic              win_s;
  logic              push_s;
  logic              pop_s;
  logic              cap_s;
  logic              err_s;

  lifo_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (wdata_r),
    .rd_data (top_s),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  assign win_s = rr_pick(c0_req, c1_req, rr_last_r);

  // Legality check and stack strobes; only the GRANT cycle touches the stack.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    cap_s  = 1'b0;
    err_s  = 1'b0;
    if (state_r == S_GRANT) begin
      case (op_r)
        OP_PUSH: if (full)  err_s = 1'b1; else push_s = 1'b1;
        OP_POP:  if (empty) err_s = 1'b1; else begin cap_s = 1'b1; pop_s = 1'b1; end
`ifdef STACK_ARB_PEEK_EN
        OP_PEEK: if (empty) err_s = 1'b1; else cap_s = 1'b1;
`endif
        default: err_s = 1'b1;
      endcase
    end else begin
      err_s = 1'b0;
    end
  end

  // Arbitration FSM with registered per-client responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      win_r     <= 1'b0;
      rr_last_r <= 1'b1;
      op_r      <= OP_PUSH;
      wdata_r   <= {DATA_W{1'b0}};
      c0_ack    <= 1'b0;
      c0_err    <= 1'b0;
      c0_rdata  <= {DATA_W{1'b0}};
      c1_ack    <= 1'b0;
      c1_err    <= 1'b0;
      c1_rdata  <= {DATA_W{1'b0}};
      busy      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          c0_ack <= 1'b0;
          c1_ack <= 1'b0;
          c0_err <= 1'b0;
          c1_err <= 1'b0;
          if (c0_req || c1_req) begin
            win_r   <= win_s;
            op_r    <= win_s ? op_e'(c1_op) : op_e'(c0_op);
            wdata_r <= win_s ? c1_wdata : c0_wdata;
            state_r <= S_GRANT;
            busy    <= 1'b1;
          end else begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_GRANT: begin
          // Response lands with the ack so rdata never changes ahead of it.
          if (win_r) begin
            c1_ack <= 1'b1;
            c1_err <= err_s;
            if (cap_s) c1_rdata <= top_s;
          end else begin
            c0_ack <= 1'b1;
            c0_err <= err_s;
            if (cap_s) c0_rdata <= top_s;
          end
          state_r <= S_ACK;
          busy    <= 1'b1;
        end
        S_ACK: begin
          c0_ack    <= 1'b0;
          c1_ack    <= 1'b0;
          c0_err    <= 1'b0;
          c1_err    <= 1'b0;
          rr_last_r <= win_r;
          state_r   <= S_IDLE;
          busy      <= 1'b0;
        end
        default: begin
          c0_ack  <= 1'b0;
          c1_ack  <= 1'b0;
          c0_err  <= 1'b0;
          c1_err  <= 1'b0;
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_rr_arbiter.sv
// Self-checking bench for stack_rr_arbiter: vector table plus hand-written corner sequences,
// with expected responses queued at issue time and checked when an ack appears.
module tb_stack_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       c0_req, c1_req;
  logic [1:0] c0_op, c1_op;
  logic [7:0] c0_wdata, c1_wdata;
  logic       c0_ack, c1_ack, c0_err, c1_err;
  logic [7:0] c0_rdata, c1_rdata;
  logic [4:0] level;
  logic       full, empty, busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       cl;
    logic       err;
    logic [7:0] rd;
    logic [4:0] lvl;
  } exp_t;

  typedef struct {
    logic       cl;
    logic [1:0] op;
    logic [7:0] wd;
    logic       err;
    logic [7:0] rd;
    logic [4:0] lvl;
    int         lat;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[11];

`ifdef STACK_ARB_PEEK_EN
  localparam logic       PK_ERR = 1'b0;
  localparam logic [7:0] PK_RD  = 8'h33;
`else
  localparam logic       PK_ERR = 1'b1;
  localparam logic [7:0] PK_RD  = 8'h00;
`endif

  stack_rr_arbiter dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_op(c0_op), .c0_wdata(c0_wdata),
    .c0_ack(c0_ack), .c0_rdata(c0_rdata), .c0_err(c0_err),
    .c1_req(c1_req), .c1_op(c1_op), .c1_wdata(c1_wdata),
    .c1_ack(c1_ack), .c1_rdata(c1_rdata), .c1_err(c1_err),
    .level(level), .full(full), .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_ack();
    exp_t e;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_ack: got ack with empty scoreboard expected none");
    end else begin
      e = sbq.pop_front();
      chk("ack_overlap", 32'(c0_ack & c1_ack), 32'd0);
      chk("ack_client", 32'(c1_ack), 32'(e.cl));
      chk("err", 32'(e.cl ? c1_err : c0_err), 32'(e.err));
      chk("rdata", 32'(e.cl ? c1_rdata : c0_rdata), 32'(e.rd));
      chk("level", 32'(level), 32'(e.lvl));
    end
  endtask

  task automatic issue(input logic cl, input logic [1:0] op, input logic [7:0] wd,
                       input logic e_err, input logic [7:0] e_rd, input logic [4:0] e_lvl,
                       input int e_lat);
    int  lat;
    bit  got;
    sbq.push_back('{cl: cl, err: e_err, rd: e_rd, lvl: e_lvl});
    if (cl) begin c1_op = op; c1_wdata = wd; c1_req = 1'b1; end
    else    begin c0_op = op; c0_wdata = wd; c0_req = 1'b1; end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (c0_ack || c1_ack) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout: got no ack after %0d cycles expected ack from client %0d", lat, cl);
      void'(sbq.pop_front());
    end else begin
      check_ack();
      if (e_lat > 0) chk("latency", 32'(lat), 32'(e_lat));
    end
    c0_req = 1'b0;
    c1_req = 1'b0;
  endtask

  initial begin
    int nack;
    int quiet;
    vecs[0]  = '{cl: 1'b0, op: 2'b00, wd: 8'hA5, err: 1'b0,   rd: 8'h00, lvl: 5'd1, lat: 2};
    vecs[1]  = '{cl: 1'b1, op: 2'b01, wd: 8'h00, err: 1'b0,   rd: 8'hA5, lvl: 5'd0, lat: 0};
    vecs[2]  = '{cl: 1'b1, op: 2'b01, wd: 8'h00, err: 1'b1,   rd: 8'hA5, lvl: 5'd0, lat: 0};
    vecs[3]  = '{cl: 1'b0, op: 2'b11, wd: 8'h77, err: 1'b1,   rd: 8'h00, lvl: 5'd0, lat: 0};
    vecs[4]  = '{cl: 1'b0, op: 2'b00, wd: 8'h11, err: 1'b0,   rd: 8'h00, lvl: 5'd1, lat: 0};
    vecs[5]  = '{cl: 1'b0, op: 2'b00, wd: 8'h22, err: 1'b0,   rd: 8'h00, lvl: 5'd2, lat: 0};
    vecs[6]  = '{cl: 1'b0, op: 2'b00, wd: 8'h33, err: 1'b0,   rd: 8'h00, lvl: 5'd3, lat: 0};
    vecs[7]  = '{cl: 1'b0, op: 2'b10, wd: 8'h00, err: PK_ERR, rd: PK_RD, lvl: 5'd3, lat: 0};
    vecs[8]  = '{cl: 1'b1, op: 2'b01, wd: 8'h00, err: 1'b0,   rd: 8'h33, lvl: 5'd2, lat: 0};
    vecs[9]  = '{cl: 1'b1, op: 2'b01, wd: 8'h00, err: 1'b0,   rd: 8'h22, lvl: 5'd1, lat: 0};
    vecs[10] = '{cl: 1'b1, op: 2'b01, wd: 8'h00, err: 1'b0,   rd: 8'h11, lvl: 5'd0, lat: 0};

    rst = 1'b1;
    c0_req = 1'b0; c1_req = 1'b0;
    c0_op = 2'b00; c1_op = 2'b00;
    c0_wdata = 8'h00; c1_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'({c0_ack, c1_ack, c0_err, c1_err}), 32'd0);
    chk("rst_rdata", 32'({c0_rdata, c1_rdata}), 32'd0);
    chk("rst_flags", 32'({level, full, empty, busy}), 32'({5'd0, 1'b0, 1'b1, 1'b0}));
    rst = 1'b0;

    // push/pop handoff, empty pop, reserved op, peek
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].cl, vecs[i].op, vecs[i].wd, vecs[i].err, vecs[i].rd, vecs[i].lvl, vecs[i].lat);
    end
    chk("empty_after_table", 32'(empty), 32'd1);

    // both clients request together; last winner was client 1, so order is c0,c1,c0,c1
    c0_op = 2'b00; c0_wdata = 8'h01;
    c1_op = 2'b00; c1_wdata = 8'h02;
    sbq.push_back('{cl: 1'b0, err: 1'b0, rd: PK_RD, lvl: 5'd1});
    sbq.push_back('{cl: 1'b1, err: 1'b0, rd: 8'h11, lvl: 5'd2});
    sbq.push_back('{cl: 1'b0, err: 1'b0, rd: PK_RD, lvl: 5'd3});
    sbq.push_back('{cl: 1'b1, err: 1'b0, rd: 8'h11, lvl: 5'd4});
    c0_req = 1'b1; c1_req = 1'b1;
    nack = 0;
    for (int k = 0; k < 40 && nack < 4; k++) begin
      @(posedge clk); #1;
      if (c0_ack || c1_ack) begin
        check_ack();
        nack++;
        if (nack == 4) begin c0_req = 1'b0; c1_req = 1'b0; end
      end
    end
    c0_req = 1'b0; c1_req = 1'b0;
    chk("rr_ack_count", 32'(nack), 32'd4);
    sbq.delete();
    issue(1'b0, 2'b01, 8'h00, 1'b0, 8'h02, 5'd3, 0);
    issue(1'b0, 2'b01, 8'h00, 1'b0, 8'h01, 5'd2, 0);
    issue(1'b0, 2'b01, 8'h00, 1'b0, 8'h02, 5'd1, 0);
    issue(1'b0, 2'b01, 8'h00, 1'b0, 8'h01, 5'd0, 0);

    // fill to DEPTH, overflow, reserved op at full, then drain in LIFO order
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 2'b00, 8'(8'hF0 + i), 1'b0, 8'h01, 5'(i + 1), 0);
    end
    chk("full_at_16", 32'(full), 32'd1);
    issue(1'b1, 2'b00, 8'hEE, 1'b1, 8'h11, 5'd16, 0);
    issue(1'b0, 2'b11, 8'h00, 1'b1, 8'h01, 5'd16, 0);
    for (int i = 0; i < 16; i++) begin
      issue(1'b1, 2'b01, 8'h00, 1'b0, 8'(8'hFF - i), 5'(15 - i), 0);
    end
    chk("empty_after_drain", 32'({full, empty}), 32'({1'b0, 1'b1}));

    // reset during the GRANT cycle of a push at level 5
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, 2'b00, 8'(8'h50 + i), 1'b0, 8'h01, 5'(i + 1), 0);
    end
    c0_op = 2'b00; c0_wdata = 8'h99; c0_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_in_grant", 32'({busy, level}), 32'({1'b1, 5'd5}));
    rst = 1'b1;
    c0_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_flags", 32'({c0_ack, c1_ack, level, empty, busy}), 32'({1'b0, 1'b0, 5'd0, 1'b1, 1'b0}));
    quiet = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (c0_ack || c1_ack || busy) quiet++;
    end
    chk("abort_no_late_ack", 32'(quiet), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
